mccu_replenish: RTL and testbench

Parametrised next-generation Maximum-Contention Control Unit. Keeps a per-core contention quota and decrements it each cycle by the summed weights of that core's asserted contention events. Adds three things to the base unit: a periodic replenishment window that reloads every quota, sticky per-core interrupts with explicit clear, and a per-core state machine. Sits between the core event buses and the interrupt controller; software programs it through the quota and weight inputs.

---
 rtl/mccu_replenish_if.sv | 51 +++++
 rtl/mccu_replenish.sv | 220 ++++++++++++++++++++++
 tb/tb_mccu_replenish.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mccu_replenish_if.sv
// mccu_replenish_if: event, quota, window and interrupt signals of the
// Maximum-Contention Control Unit with replenishment.
// The slave modport is the unit itself; the master modport is the side that
// programs it and watches its outputs.
// Optional feature macro: MCCU_OVERRUN_EN adds the per-core overrun_o bus.
interface mccu_replenish_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int WEIGHTS_WIDTH = 7,
    parameter int N_CORES       = 4,
    parameter int CORE_EVENTS   = 4,
    parameter int PERIOD_WIDTH  = 16
) ();
    logic                                        enable_i;
    logic [N_CORES*CORE_EVENTS-1:0]              events_i;
    logic [N_CORES*CORE_EVENTS*WEIGHTS_WIDTH-1:0] events_weights_i;
    logic [N_CORES*DATA_WIDTH-1:0]               quota_i;
    logic [N_CORES-1:0]                          update_quota_i;
    logic                                        replenish_en_i;
    logic [PERIOD_WIDTH-1:0]                     period_i;
    logic [N_CORES-1:0]                          irq_clear_i;
    logic [N_CORES*DATA_WIDTH-1:0]               quota_o;
    logic [N_CORES-1:0]                          interruption_quota_o;
    logic                                        replenish_o;
`ifdef MCCU_OVERRUN_EN
    logic [N_CORES*DATA_WIDTH-1:0]               overrun_o;

    modport slave (
        input  enable_i, events_i, events_weights_i, quota_i, update_quota_i,
               replenish_en_i, period_i, irq_clear_i,
        output quota_o, interruption_quota_o, replenish_o, overrun_o
    );

    modport master (
        output enable_i, events_i, events_weights_i, quota_i, update_quota_i,
               replenish_en_i, period_i, irq_clear_i,
        input  quota_o, interruption_quota_o, replenish_o, overrun_o
    );
`else
    modport slave (
        input  enable_i, events_i, events_weights_i, quota_i, update_quota_i,
               replenish_en_i, period_i, irq_clear_i,
        output quota_o, interruption_quota_o, replenish_o
    );

    modport master (
        output enable_i, events_i, events_weights_i, quota_i, update_quota_i,
               replenish_en_i, period_i, irq_clear_i,
        input  quota_o, interruption_quota_o, replenish_o
    );
`endif
endinterface

// File: rtl/mccu_replenish.sv
// mccu_replenish: per-core contention quota counters with saturating
// weighted decrement, a periodic replenishment window that reloads every
// quota, sticky per-core "quota exhausted" interrupts and a per-core
// IDLE/ACTIVE/EXHAUSTED state machine. All outputs come straight from flops.
// Optional feature macro: MCCU_OVERRUN_EN adds a saturating per-core overrun
// accumulator exported on overrun_o.
module mccu_replenish #(
    parameter int DATA_WIDTH    = 32,
    parameter int WEIGHTS_WIDTH = 7,
    parameter int N_CORES       = 4,
    parameter int CORE_EVENTS   = 4,
    parameter int PERIOD_WIDTH  = 16
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    mccu_replenish_if.slave   bus
);

    // Worst case all events fire with maximum weight; this width holds it.
    localparam int SUM_W = WEIGHTS_WIDTH + $clog2(CORE_EVENTS + 1);
    // Common width used to compare/subtract sum against remaining quota.
    localparam int CMP_W = (SUM_W > DATA_WIDTH) ? SUM_W : DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ACTIVE    = 2'd1,
        ST_EXHAUSTED = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Replenishment window (shared by all cores)
    // ------------------------------------------------------------------
    logic [PERIOD_WIDTH-1:0] win_cnt_q, win_cnt_d;
    logic                    win_run;
    logic                    win_fire;
    logic                    replenish_q;

    assign win_run = bus.enable_i && bus.replenish_en_i && (bus.period_i != '0);

    // Window counter next state: reload on the last count, silent wrap if the
    // period was shortened underneath the running count.
    always_comb begin
        win_cnt_d = win_cnt_q;
        win_fire  = 1'b0;
        if (win_run) begin
            if (win_cnt_q == (bus.period_i - PERIOD_WIDTH'(1))) begin
                win_cnt_d = '0;
                win_fire  = 1'b1;
            end else if (win_cnt_q >= bus.period_i) begin
                win_cnt_d = '0;
            end else begin
                win_cnt_d = win_cnt_q + PERIOD_WIDTH'(1);
            end
        end
    end

    // Window counter and the registered reload pulse.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            win_cnt_q   <= '0;
            replenish_q <= 1'b0;
        end else begin
            win_cnt_q   <= win_cnt_d;
            replenish_q <= win_fire;
        end
    end

    assign bus.replenish_o = replenish_q;

    // ------------------------------------------------------------------
    // Per-core datapath, interrupt and state machine
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < N_CORES; gi++) begin : g_core
        logic [CORE_EVENTS-1:0]               ev;
        logic [CORE_EVENTS*WEIGHTS_WIDTH-1:0] wts;
        logic [SUM_W-1:0]                     partial [CORE_EVENTS+1];
        logic [SUM_W-1:0]                     sum;
        logic [CMP_W-1:0]                     sum_ext;
        logic [CMP_W-1:0]                     rem_ext;
        logic [DATA_WIDTH-1:0]                quota_in;
        logic [DATA_WIDTH-1:0]                rem_q, rem_d;
        logic [DATA_WIDTH-1:0]                reload_q, reload_d;
        logic                                 load;
        logic                                 consume;
        logic                                 irq_q, irq_d;
        state_t                               state_q, state_d;

        assign ev       = bus.events_i[gi*CORE_EVENTS +: CORE_EVENTS];
        assign wts      = bus.events_weights_i[gi*CORE_EVENTS*WEIGHTS_WIDTH +:
                                               CORE_EVENTS*WEIGHTS_WIDTH];
        assign quota_in = bus.quota_i[gi*DATA_WIDTH +: DATA_WIDTH];
        assign load     = bus.update_quota_i[gi];

        // Weighted event sum built as a prefix chain so every index is static.
        assign partial[0] = '0;
        for (genvar gj = 0; gj < CORE_EVENTS; gj++) begin : g_sum
            assign partial[gj+1] = partial[gj] +
                (ev[gj] ? SUM_W'(wts[gj*WEIGHTS_WIDTH +: WEIGHTS_WIDTH]) : SUM_W'(0));
        end
        assign sum = partial[CORE_EVENTS];

        assign sum_ext = CMP_W'(sum);
        assign rem_ext = CMP_W'(rem_q);

        // IDLE never decrements; the first enabled cycle only leaves IDLE.
        assign consume = bus.enable_i && (state_q != ST_IDLE);

        // Remaining quota: load beats window reload beats saturating decrement.
        always_comb begin
            rem_d    = rem_q;
            reload_d = reload_q;
            if (load) begin
                rem_d    = quota_in;
                reload_d = quota_in;
            end else if (win_fire) begin
                rem_d = reload_q;
            end else if (consume) begin
                if (sum_ext >= rem_ext) begin
                    rem_d = '0;
                end else begin
                    rem_d = DATA_WIDTH'(rem_ext - sum_ext);
                end
            end
        end

        // Core state machine: next state from enable and the next quota.
        always_comb begin
            state_d = state_q;
            if (!bus.enable_i) begin
                state_d = ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_d = (rem_d != '0) ? ST_ACTIVE : ST_EXHAUSTED;
                    end
                    ST_ACTIVE: begin
                        if (rem_d == '0) begin
                            state_d = ST_EXHAUSTED;
                        end
                    end
                    ST_EXHAUSTED: begin
                        if ((load || win_fire) && (rem_d != '0)) begin
                            state_d = ST_ACTIVE;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end

        // Sticky interrupt: clear requests lose to a same-cycle set.
        always_comb begin
            irq_d = irq_q;
            if (bus.irq_clear_i[gi] || load) begin
                irq_d = 1'b0;
            end
            if (bus.enable_i && (rem_d == '0)) begin
                irq_d = 1'b1;
            end
        end

        // Per-core state registers.
        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                rem_q    <= '0;
                reload_q <= '0;
                irq_q    <= 1'b0;
                state_q  <= ST_IDLE;
            end else begin
                rem_q    <= rem_d;
                reload_q <= reload_d;
                irq_q    <= irq_d;
                state_q  <= state_d;
            end
        end

        assign bus.quota_o[gi*DATA_WIDTH +: DATA_WIDTH] = rem_q;
        assign bus.interruption_quota_o[gi]             = irq_q;

`ifdef MCCU_OVERRUN_EN
        localparam logic [CMP_W:0] OVR_MAX =
            {{(CMP_W+1-DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};

        logic [DATA_WIDTH-1:0] ovr_q, ovr_d;
        logic [CMP_W-1:0]      excess;
        logic [CMP_W:0]        ovr_sum;

        // Overrun accumulates demand beyond the quota; since an exhausted
        // core holds zero, its full sum counts as excess automatically.
        always_comb begin
            ovr_d   = ovr_q;
            excess  = '0;
            ovr_sum = '0;
            if (load || win_fire) begin
                ovr_d = '0;
            end else if (consume && (sum_ext > rem_ext)) begin
                excess  = sum_ext - rem_ext;
                ovr_sum = {1'b0, CMP_W'(ovr_q)} + {1'b0, excess};
                if (ovr_sum >= OVR_MAX) begin
                    ovr_d = '1;
                end else begin
                    ovr_d = DATA_WIDTH'(ovr_sum);
                end
            end
        end

        // Overrun accumulator register.
        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                ovr_q <= '0;
            end else begin
                ovr_q <= ovr_d;
            end
        end

        assign bus.overrun_o[gi*DATA_WIDTH +: DATA_WIDTH] = ovr_q;
`endif
    end

endmodule

// File: tb/tb_mccu_replenish.sv
// Directed bench for mccu_replenish: load, hold while disabled, decrement,
// saturation, sticky interrupt, replenish window with pause, same-cycle
// load/reload collision, period shrink, async reset, optional overrun.
module tb_mccu_replenish;
    localparam int DW = 32;
    localparam int WW = 7;
    localparam int NC = 4;
    localparam int CE = 4;
    localparam int PW = 16;

    logic clk;
    logic rstn;
    int   total;
    int   bad;

    mccu_replenish_if #(.DATA_WIDTH(DW), .WEIGHTS_WIDTH(WW), .N_CORES(NC),
                        .CORE_EVENTS(CE), .PERIOD_WIDTH(PW)) bus ();

    mccu_replenish #(.DATA_WIDTH(DW), .WEIGHTS_WIDTH(WW), .N_CORES(NC),
                     .CORE_EVENTS(CE), .PERIOD_WIDTH(PW)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] q_of(input int c);
        logic [NC*DW-1:0] tmp;
        tmp = bus.quota_o >> (c * DW);
        return tmp[DW-1:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_quota(input int c, input logic [DW-1:0] v);
        logic [NC*DW-1:0] mask;
        mask = {{(NC-1)*DW{1'b0}}, {DW{1'b1}}} << (c * DW);
        bus.quota_i = (bus.quota_i & ~mask) | ({{(NC-1)*DW{1'b0}}, v} << (c * DW));
    endtask

    task automatic set_weight(input int c, input int e, input logic [WW-1:0] w);
        logic [NC*CE*WW-1:0] mask;
        mask = {{(NC*CE-1)*WW{1'b0}}, {WW{1'b1}}} << ((c*CE + e) * WW);
        bus.events_weights_i = (bus.events_weights_i & ~mask) |
                               ({{(NC*CE-1)*WW{1'b0}}, w} << ((c*CE + e) * WW));
    endtask

    task automatic set_event(input int c, input int e, input logic b);
        logic [NC*CE-1:0] bitm;
        bitm = {{(NC*CE-1){1'b0}}, 1'b1} << (c*CE + e);
        if (b) bus.events_i = bus.events_i | bitm;
        else   bus.events_i = bus.events_i & ~bitm;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        step();
        step();
        total++;
        if (bus.quota_o !== '0) begin
            bad++; $display("FAIL reset_quota: got %h expected 0", bus.quota_o);
        end
        total++;
        if (bus.interruption_quota_o !== 4'b0000) begin
            bad++; $display("FAIL reset_irq: got %b expected 0000", bus.interruption_quota_o);
        end
        total++;
        if (bus.replenish_o !== 1'b0) begin
            bad++; $display("FAIL reset_replenish: got %b expected 0", bus.replenish_o);
        end
        rstn = 1'b1;
        step();
        total++;
        if (bus.quota_o !== '0 || bus.interruption_quota_o !== 4'b0000) begin
            bad++; $display("FAIL reset_release: quota %h irq %b expected 0/0000",
                            bus.quota_o, bus.interruption_quota_o);
        end
        $display("test_reset done");
    endtask

    task automatic test_load();
        bus.enable_i = 1'b1;
        set_quota(0, 150);
        bus.update_quota_i = 4'b0001;
        step();
        bus.update_quota_i = 4'b0000;
        total++;
        if (q_of(0) !== 150) begin
            bad++; $display("FAIL load_150: got %0d expected 150", q_of(0));
        end
        total++;
        if (bus.interruption_quota_o !== 4'b1110) begin
            bad++; $display("FAIL load_irq: got %b expected 1110", bus.interruption_quota_o);
        end
        set_quota(0, 200);
        bus.update_quota_i = 4'b0001;
        step();
        bus.update_quota_i = 4'b0000;
        bus.enable_i = 1'b0;
        set_weight(0, 0, 10);
        set_event(0, 0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if (q_of(0) !== 200) begin
                bad++; $display("FAIL hold_disabled[%0d]: got %0d expected 200", k, q_of(0));
            end
        end
        $display("test_load done");
    endtask

    task automatic test_decrement();
        bus.events_i = '0;
        bus.enable_i = 1'b1;
        step();
        total++;
        if (q_of(0) !== 200) begin
            bad++; $display("FAIL dec_enter: got %0d expected 200", q_of(0));
        end
        set_event(0, 0, 1'b1);
        step();
        total++;
        if (q_of(0) !== 190) begin
            bad++; $display("FAIL dec_190: got %0d expected 190", q_of(0));
        end
        step();
        bus.events_i = '0;
        total++;
        if (q_of(0) !== 180) begin
            bad++; $display("FAIL dec_180: got %0d expected 180", q_of(0));
        end
        total++;
        if (bus.interruption_quota_o[0] !== 1'b0) begin
            bad++; $display("FAIL dec_irq: got %b expected 0", bus.interruption_quota_o[0]);
        end
        step();
        total++;
        if (q_of(0) !== 180) begin
            bad++; $display("FAIL dec_idle_events: got %0d expected 180", q_of(0));
        end
        $display("test_decrement done");
    endtask

    task automatic test_saturate();
        for (int e = 0; e < CE; e++) set_weight(0, e, 10);
        set_quota(0, 25);
        bus.update_quota_i = 4'b0001;
        step();
        bus.update_quota_i = 4'b0000;
        total++;
        if (q_of(0) !== 25) begin
            bad++; $display("FAIL sat_load: got %0d expected 25", q_of(0));
        end
        bus.events_i = 16'h000F;
        step();
        bus.events_i = '0;
        total++;
        if (q_of(0) !== 0) begin
            bad++; $display("FAIL sat_zero: got %0d expected 0", q_of(0));
        end
        total++;
        if (bus.interruption_quota_o[0] !== 1'b1) begin
            bad++; $display("FAIL sat_irq: got %b expected 1", bus.interruption_quota_o[0]);
        end
        step();
        total++;
        if (q_of(0) !== 0) begin
            bad++; $display("FAIL sat_stay: got %0d expected 0", q_of(0));
        end
        $display("test_saturate done");
    endtask

    task automatic test_irq_set_wins();
        do_reset();
        bus.enable_i = 1'b1;
        set_event(0, 0, 1'b1);
        step();
        bus.events_i = '0;
        total++;
        if (bus.interruption_quota_o[0] !== 1'b1 || q_of(0) !== 0) begin
            bad++; $display("FAIL irq_zero: irq %b quota %0d expected 1/0",
                            bus.interruption_quota_o[0], q_of(0));
        end
        bus.irq_clear_i = 4'b0001;
        step();
        bus.irq_clear_i = 4'b0000;
        total++;
        if (bus.interruption_quota_o[0] !== 1'b1) begin
            bad++; $display("FAIL irq_set_wins: got %b expected 1", bus.interruption_quota_o[0]);
        end
        set_quota(0, 50);
        bus.update_quota_i = 4'b0001;
        step();
        bus.update_quota_i = 4'b0000;
        total++;
        if (bus.interruption_quota_o[0] !== 1'b0 || q_of(0) !== 50) begin
            bad++; $display("FAIL irq_load_clear: irq %b quota %0d expected 0/50",
                            bus.interruption_quota_o[0], q_of(0));
        end
        bus.enable_i = 1'b0;
        bus.irq_clear_i = 4'b0010;
        step();
        bus.irq_clear_i = 4'b0000;
        total++;
        if (bus.interruption_quota_o[2:1] !== 2'b10) begin
            bad++; $display("FAIL irq_clear_sticky: got %b expected 10", bus.interruption_quota_o[2:1]);
        end
        $display("test_irq_set_wins done");
    endtask

    task automatic test_replenish();
        do_reset();
        bus.enable_i = 1'b0;
        bus.events_i = '0;
        set_quota(0, 100);
        set_quota(1, 30);
        set_quota(2, 60);
        bus.update_quota_i = 4'b0111;
        step();
        bus.update_quota_i = 4'b0000;
        set_weight(1, 0, 5);
        bus.enable_i = 1'b1;
        bus.replenish_en_i = 1'b1;
        bus.period_i = 16'd8;
        step();
        total++;
        if (q_of(1) !== 30 || bus.replenish_o !== 1'b0) begin
            bad++; $display("FAIL rep_start: quota %0d rep %b expected 30/0", q_of(1), bus.replenish_o);
        end
        set_event(1, 0, 1'b1);
        for (int k = 2; k <= 7; k++) begin
            step();
            total++;
            if (q_of(1) !== 32'(30 - 5*(k-1)) || bus.replenish_o !== 1'b0) begin
                bad++; $display("FAIL rep_count[%0d]: quota %0d rep %b expected %0d/0",
                                k, q_of(1), bus.replenish_o, 30 - 5*(k-1));
            end
        end
        total++;
        if (bus.interruption_quota_o[1] !== 1'b1) begin
            bad++; $display("FAIL rep_irq_set: got %b expected 1", bus.interruption_quota_o[1]);
        end
        step();
        total++;
        if (bus.replenish_o !== 1'b1 || q_of(1) !== 30 || q_of(0) !== 100 ||
            bus.interruption_quota_o[1] !== 1'b1) begin
            bad++; $display("FAIL rep_fire: rep %b q1 %0d q0 %0d irq1 %b expected 1/30/100/1",
                            bus.replenish_o, q_of(1), q_of(0), bus.interruption_quota_o[1]);
        end
        step();
        total++;
        if (bus.replenish_o !== 1'b0 || q_of(1) !== 25) begin
            bad++; $display("FAIL rep_after: rep %b q1 %0d expected 0/25", bus.replenish_o, q_of(1));
        end
        bus.events_i = '0;
        bus.enable_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if (bus.replenish_o !== 1'b0 || q_of(1) !== 25) begin
                bad++; $display("FAIL rep_pause[%0d]: rep %b q1 %0d expected 0/25",
                                k, bus.replenish_o, q_of(1));
            end
        end
        bus.enable_i = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            total++;
            if (bus.replenish_o !== 1'b0) begin
                bad++; $display("FAIL rep_resume[%0d]: rep %b expected 0", k, bus.replenish_o);
            end
        end
        step();
        total++;
        if (bus.replenish_o !== 1'b1 || q_of(1) !== 30 || bus.interruption_quota_o[1] !== 1'b1) begin
            bad++; $display("FAIL rep_fire2: rep %b q1 %0d irq1 %b expected 1/30/1",
                            bus.replenish_o, q_of(1), bus.interruption_quota_o[1]);
        end
        bus.irq_clear_i = 4'b0010;
        step();
        bus.irq_clear_i = 4'b0000;
        total++;
        if (bus.interruption_quota_o[1] !== 1'b0) begin
            bad++; $display("FAIL rep_irq_clear: got %b expected 0", bus.interruption_quota_o[1]);
        end
        $display("test_replenish done");
    endtask

    task automatic test_collision();
        do_reset();
        bus.enable_i = 1'b0;
        bus.events_i = '0;
        bus.replenish_en_i = 1'b0;
        set_quota(0, 100);
        set_quota(1, 30);
        set_quota(2, 60);
        set_quota(3, 0);
        bus.update_quota_i = 4'b0111;
        step();
        bus.update_quota_i = 4'b0000;
        set_weight(2, 0, 7);
        bus.enable_i = 1'b1;
        bus.replenish_en_i = 1'b1;
        bus.period_i = 16'd8;
        step();
        set_event(0, 0, 1'b1);
        for (int k = 2; k <= 7; k++) begin
            step();
            total++;
            if (q_of(0) !== 32'(100 - 10*(k-1))) begin
                bad++; $display("FAIL col_pre[%0d]: got %0d expected %0d", k, q_of(0), 100 - 10*(k-1));
            end
        end
        set_quota(2, 77);
        bus.update_quota_i = 4'b0100;
        step();
        bus.update_quota_i = 4'b0000;
        total++;
        if (bus.replenish_o !== 1'b1 || q_of(0) !== 100 || q_of(1) !== 30 || q_of(2) !== 77) begin
            bad++; $display("FAIL col_fire: rep %b q0 %0d q1 %0d q2 %0d expected 1/100/30/77",
                            bus.replenish_o, q_of(0), q_of(1), q_of(2));
        end
        set_event(2, 0, 1'b1);
        for (int j = 1; j <= 7; j++) begin
            step();
            total++;
            if (q_of(0) !== 32'(100 - 10*j) || q_of(2) !== 32'(77 - 7*j) || bus.replenish_o !== 1'b0) begin
                bad++; $display("FAIL col_run[%0d]: q0 %0d q2 %0d rep %b expected %0d/%0d/0",
                                j, q_of(0), q_of(2), bus.replenish_o, 100 - 10*j, 77 - 7*j);
            end
        end
        step();
        total++;
        if (bus.replenish_o !== 1'b1 || q_of(0) !== 100 || q_of(2) !== 77) begin
            bad++; $display("FAIL col_reload77: rep %b q0 %0d q2 %0d expected 1/100/77",
                            bus.replenish_o, q_of(0), q_of(2));
        end
        set_event(2, 0, 1'b0);
        repeat (5) step();
        bus.period_i = 16'd4;
        for (int j = 1; j <= 4; j++) begin
            step();
            total++;
            if (q_of(0) !== 32'(50 - 10*j) || bus.replenish_o !== 1'b0) begin
                bad++; $display("FAIL shrink[%0d]: q0 %0d rep %b expected %0d/0",
                                j, q_of(0), bus.replenish_o, 50 - 10*j);
            end
        end
        step();
        total++;
        if (bus.replenish_o !== 1'b1 || q_of(0) !== 100) begin
            bad++; $display("FAIL shrink_fire: rep %b q0 %0d expected 1/100", bus.replenish_o, q_of(0));
        end
        bus.events_i = '0;
        bus.replenish_en_i = 1'b0;
        $display("test_collision done");
    endtask

`ifdef MCCU_OVERRUN_EN
    task automatic test_overrun();
        bus.enable_i = 1'b1;
        bus.replenish_en_i = 1'b0;
        set_weight(3, 0, 12);
        set_quota(3, 5);
        bus.update_quota_i = 4'b1000;
        step();
        bus.update_quota_i = 4'b0000;
        set_event(3, 0, 1'b1);
        step();
        total++;
        if (bus.overrun_o[3*DW +: DW] !== 32'd7 || q_of(3) !== 0) begin
            bad++; $display("FAIL overrun_7: ovr %0d q3 %0d expected 7/0", bus.overrun_o[3*DW +: DW], q_of(3));
        end
        step();
        set_event(3, 0, 1'b0);
        total++;
        if (bus.overrun_o[3*DW +: DW] !== 32'd19) begin
            bad++; $display("FAIL overrun_19: got %0d expected 19", bus.overrun_o[3*DW +: DW]);
        end
        set_quota(3, 9);
        bus.update_quota_i = 4'b1000;
        step();
        bus.update_quota_i = 4'b0000;
        total++;
        if (bus.overrun_o[3*DW +: DW] !== 32'd0) begin
            bad++; $display("FAIL overrun_clear: got %0d expected 0", bus.overrun_o[3*DW +: DW]);
        end
        $display("test_overrun done");
    endtask
`endif

    task automatic test_async_reset();
        bus.enable_i = 1'b1;
        set_quota(0, 123);
        bus.update_quota_i = 4'b0001;
        step();
        bus.update_quota_i = 4'b0000;
        rstn = 1'b0;
        #2;
        total++;
        if (bus.quota_o !== '0 || bus.interruption_quota_o !== 4'b0000 || bus.replenish_o !== 1'b0) begin
            bad++; $display("FAIL async_reset: quota %h irq %b rep %b expected 0",
                            bus.quota_o, bus.interruption_quota_o, bus.replenish_o);
        end
        step();
        rstn = 1'b1;
        $display("test_async_reset done");
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rstn  = 1'b0;
        bus.enable_i         = 1'b0;
        bus.events_i         = '0;
        bus.events_weights_i = '0;
        bus.quota_i          = '0;
        bus.update_quota_i   = '0;
        bus.replenish_en_i   = 1'b0;
        bus.period_i         = '0;
        bus.irq_clear_i      = '0;
        test_reset();
        test_load();
        test_decrement();
        test_saturate();
        test_irq_set_wins();
        test_replenish();
        test_collision();
`ifdef MCCU_OVERRUN_EN
        test_overrun();
`endif
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
